vram_spram_arb: RTL and testbench
=================================

VRAM_SPRAM_ARB -- requirements
Module: vram_spram_arb

Interface
REQ-001 Parameter NUM_BANKS, default 2, SHALL be the number of SB_SPRAM256KA banks (legal: 1, 2, 4); capacity is 32KB per bank.
REQ-002 Parameter ARB_MODE, default 0, SHALL select arbitration: 0 = round-robin, 1 = fixed priority to port B.
REQ-003 Derived localparam ADDR_W SHALL equal 15 + log2(NUM_BANKS).
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 a_req  in  1  port A (CPU) access request.
REQ-007 a_we  in  1  port A write enable (1 = write, 0 = read).
REQ-008 a_addr  in  ADDR_W  port A byte address.
REQ-009 a_wdata  in  8  port A write byte.
REQ-010 a_gnt  out  1  port A request accepted this cycle (combinational).
REQ-011 a_rdata  out  8  port A read data.
REQ-012 a_rvalid  out  1  port A read data valid, one-cycle pulse.
REQ-013 b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid SHALL mirror REQ-006..REQ-012 for port B (video).

Function
REQ-014 Address decode: bank = addr[ADDR_W-1:15], SPRAM word = addr[14:1], byte lane = addr[0] (1 = bits 15:8).
REQ-015 At most one access SHALL be issued per cycle; x_gnt asserts only when x_req is high and port x wins arbitration.
REQ-016 Round-robin mode: sole requester wins; if both request, winner is the port not granted most recently; pointer updates only on a grant.
REQ-017 Fixed mode: B wins whenever b_req is high; A wins only when b_req is low.
REQ-018 A granted access SHALL be presented to the selected bank at the same posedge at which gnt is high; non-selected banks SHALL see WREN low.
REQ-019 Write: MASKWREN = 4'b1100 for lane 1, 4'b0011 for lane 0; write data replicated on both byte halves; no rvalid generated.
REQ-020 Read latency: grant at edge N -> x_rdata valid and x_rvalid high for exactly the cycle following edge N+2.
REQ-021 Reads SHALL be fully pipelined: back-to-back granted reads yield back-to-back rvalid pulses in grant order.
REQ-022 Read data mux SHALL use bank and lane captured at grant, not current inputs.
REQ-023 x_rdata SHALL hold its last value when x_rvalid is low.
REQ-024 Read granted the cycle after a write to the same address SHALL return the newly written byte.
REQ-025 Ungranted requests SHALL be ignored without side effects; requester holds signals until gnt.
REQ-026 SPRAM pins: CHIPSELECT=1, STANDBY=0, SLEEP=0, POWEROFF=1 in all banks.

Reset
REQ-027 While rst high: a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=8'h00, no SPRAM write enabled.
REQ-028 After rst, round-robin pointer SHALL favour port A on the first simultaneous request.
REQ-029 Reads in flight when rst asserts SHALL be discarded; no rvalid after rst deasserts for them.
REQ-030 Memory contents SHALL NOT be cleared by rst.

Structure
REQ-031 Package vram_pkg SHALL hold ARB_RR/ARB_FIXED_B constants, the bank-count-to-address-width function and byte-lane mask constants.
REQ-032 Sub-module spram_bank SHALL wrap one SB_SPRAM256KA with lane mask and write-data replication; vram_spram_arb instantiates NUM_BANKS of them via generate.
REQ-033 Arbiter, read-tag pipeline (port id, bank, lane, valid; 2 stages) and output registers SHALL reside in vram_spram_arb.

Verification
REQ-034 Reset then A writes 8'h5A @0x0001, B writes 8'hC3 @0x0000, A reads 0x0001 -> a_rvalid 2 cycles after grant, a_rdata=8'h5A; read 0x0000 -> 8'hC3.
REQ-035 NUM_BANKS=2: write 8'h11 @0x0004 and 8'h22 @0x8004, read both -> 8'h11 and 8'h22 (no bank aliasing).
REQ-036 ARB_MODE=0, both req continuously for 6 cycles -> grants alternate A,B,A,B,A,B; ARB_MODE=1 -> B every cycle, a_gnt=0.
REQ-037 Four back-to-back A reads of 0x0010..0x0013 -> four consecutive rvalid cycles, data in address order.
REQ-038 Grant read, assert rst next cycle for 1 cycle -> no a_rvalid/b_rvalid, outputs 8'h00; post-reset read returns pre-reset data.
REQ-039 Write 8'hAA @0x0020, read same address next cycle -> 8'hAA; neighbour byte 0x0021 unchanged.

Source files
------------

// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
//   Shared constants and helpers for the dual-port VRAM arbiter built on
//   iCE40 single-port RAM banks (16K x 16 each, 32KB per bank).
//   Contents:
//     ARB_RR / ARB_FIXED_B   arbitration mode selectors
//     MASK_LANE0/MASK_LANE1  nibble write masks for the low/high byte lane
//     vram_addr_w()          byte-address width for a given bank count
//     rd_tag_t / rd_sel_t    read-tag pipeline records
// ---------------------------------------------------------------------------
package vram_pkg;

  // Arbitration modes
  localparam int ARB_RR      = 0;  // round-robin between A and B
  localparam int ARB_FIXED_B = 1;  // B (video) always wins when requesting

  // Address layout: [bank | 14-bit SPRAM word | byte lane]
  localparam int BANK_ADDR_LSB = 15;
  localparam int SPRAM_WORD_W  = 14;
  localparam int SPRAM_DATA_W  = 16;
  localparam int SPRAM_DEPTH   = 1 << SPRAM_WORD_W;

  // SPRAM write masks are per nibble; one byte lane covers two nibbles.
  localparam logic [3:0] MASK_LANE0 = 4'b0011;  // bits 7:0
  localparam logic [3:0] MASK_LANE1 = 4'b1100;  // bits 15:8

  // Bank index carried in the read tag; wide enough for the largest (4-bank)
  // configuration so the tag layout does not depend on NUM_BANKS.
  localparam int TAG_BANK_W = 2;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Stage-1 tag: travels alongside the SPRAM registered read.
  typedef struct packed {
    logic                  valid;
    port_e                 port;
    logic [TAG_BANK_W-1:0] bank;
    logic                  lane;
  } rd_tag_t;

  // Stage-2 tag: the bank has already been consumed by the word mux.
  typedef struct packed {
    logic  valid;
    port_e port;
    logic  lane;
  } rd_sel_t;

  // Number of bank-select address bits (0 for a single bank).
  function automatic int bank_sel_w(input int num_banks);
    return (num_banks <= 1) ? 0 : $clog2(num_banks);
  endfunction

  // Byte-address width: 15 bits per 32KB bank plus the bank select.
  function automatic int vram_addr_w(input int num_banks);
    return BANK_ADDR_LSB + bank_sel_w(num_banks);
  endfunction

  // Nibble write mask for a byte lane.
  function automatic logic [3:0] lane_mask(input logic lane);
    return lane ? MASK_LANE1 : MASK_LANE0;
  endfunction

endpackage

// File: rtl/spram_bank.sv
// ---------------------------------------------------------------------------
// spram_bank
//   One 16K x 16 single-port RAM bank with the SB_SPRAM256KA pin behaviour:
//   nibble write mask, registered read, static power pins. The byte-wide
//   write data is replicated onto both halves of the word and the lane
//   select is turned into the matching nibble mask, so the caller deals
//   only in bytes.
//   Ports:
//     clk        clock; write and read both on posedge
//     i_address  14-bit word address
//     i_lane     byte lane for writes (1 = bits 15:8)
//     i_wdata    write byte
//     i_wren     write enable (low = read)
//     o_dataout  16-bit registered read word (valid the cycle after access)
// ---------------------------------------------------------------------------
module spram_bank
  import vram_pkg::*;
(
  input  logic                    clk,
  input  logic [SPRAM_WORD_W-1:0] i_address,
  input  logic                    i_lane,
  input  logic [7:0]              i_wdata,
  input  logic                    i_wren,
  output logic [SPRAM_DATA_W-1:0] o_dataout
);

  // Power/select pins are tied to "always on". POWEROFF is active low on
  // the primitive, so 1 keeps the array powered and its contents retained.
  logic w_chipselect;
  logic w_standby;
  logic w_sleep;
  logic w_poweroff;
  logic w_active;

  assign w_chipselect = 1'b1;
  assign w_standby    = 1'b0;
  assign w_sleep      = 1'b0;
  assign w_poweroff   = 1'b1;
  assign w_active     = w_chipselect & ~w_standby & ~w_sleep & w_poweroff;

  logic [3:0]              w_maskwren;
  logic [SPRAM_DATA_W-1:0] w_datain;

  assign w_maskwren = lane_mask(i_lane);
  assign w_datain   = {2{i_wdata}};

  // Storage is deliberately never reset: contents survive rst.
  logic [SPRAM_DATA_W-1:0] r_mem [0:SPRAM_DEPTH-1];
  logic [SPRAM_DATA_W-1:0] r_dataout;

  always_ff @(posedge clk) begin
    if (w_active) begin
      if (i_wren) begin
        for (int n = 0; n < 4; n++) begin
          if (w_maskwren[n]) begin
            r_mem[i_address][n*4 +: 4] <= w_datain[n*4 +: 4];
          end
        end
      end
      r_dataout <= r_mem[i_address];
    end
  end

  assign o_dataout = r_dataout;

endmodule

// File: rtl/vram_spram_arb.sv
// ---------------------------------------------------------------------------
// vram_spram_arb
//   Two-port (A = CPU, B = video) byte-wide access to NUM_BANKS single-port
//   RAM banks. One access per cycle is issued; the winner is granted
//   combinationally and its access is presented to the banks at the same
//   posedge. Reads return 3 edges later through a 2-stage tag pipeline and
//   per-port output registers, fully pipelined.
//   Parameters:
//     NUM_BANKS  1, 2 or 4 banks of 32KB
//     ARB_MODE   ARB_RR (round-robin) or ARB_FIXED_B (B has priority)
//   Ports (x = a or b):
//     clk, rst     clock, synchronous active-high reset
//     x_req        access request, held until x_gnt
//     x_we         1 = write, 0 = read
//     x_addr       byte address [bank | word | lane]
//     x_wdata      write byte
//     x_gnt        request accepted this cycle (combinational)
//     x_rdata      read byte, holds between reads
//     x_rvalid     one-cycle read-data-valid pulse
// ---------------------------------------------------------------------------
module vram_spram_arb
  import vram_pkg::*;
#(
  parameter  int NUM_BANKS = 2,
  parameter  int ARB_MODE  = ARB_RR,
  localparam int ADDR_W    = vram_addr_w(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic              a_gnt,
  output logic [7:0]        a_rdata,
  output logic              a_rvalid,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic              b_gnt,
  output logic [7:0]        b_rdata,
  output logic              b_rvalid
);

  // -------------------------------------------------------------------------
  // Arbiter
  // -------------------------------------------------------------------------
  logic w_a_gnt;
  logic w_b_gnt;
  logic r_last_b;  // 1 = B was granted most recently

  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (!rst) begin
      if (ARB_MODE == ARB_FIXED_B) begin
        w_b_gnt = b_req;
        w_a_gnt = a_req & ~b_req;
      end else if (a_req && b_req) begin
        // Contention: the port that did not win last time goes now.
        w_a_gnt = r_last_b;
        w_b_gnt = ~r_last_b;
      end else begin
        w_a_gnt = a_req;
        w_b_gnt = b_req;
      end
    end
  end

  // Pointer only moves on a grant; reset value makes A win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (w_a_gnt) begin
      r_last_b <= 1'b0;
    end else if (w_b_gnt) begin
      r_last_b <= 1'b1;
    end
  end

  assign a_gnt = w_a_gnt;
  assign b_gnt = w_b_gnt;

  // -------------------------------------------------------------------------
  // Winning access, steered to the banks
  // -------------------------------------------------------------------------
  logic                  w_sel_we;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [7:0]            w_sel_wdata;
  port_e                 w_sel_port;
  logic                  w_access;
  logic                  w_wr;
  logic                  w_rd;
  logic [TAG_BANK_W-1:0] w_bank;

  always_comb begin
    w_sel_we    = a_we;
    w_sel_addr  = a_addr;
    w_sel_wdata = a_wdata;
    w_sel_port  = PORT_A;
    if (w_b_gnt) begin
      w_sel_we    = b_we;
      w_sel_addr  = b_addr;
      w_sel_wdata = b_wdata;
      w_sel_port  = PORT_B;
    end
  end

  assign w_access = w_a_gnt | w_b_gnt;
  assign w_wr     = w_access & w_sel_we;
  assign w_rd     = w_access & ~w_sel_we;

  // A single-bank build has no bank-select bits in the address.
  generate
    if (NUM_BANKS > 1) begin : g_bank_dec
      assign w_bank = TAG_BANK_W'(w_sel_addr[ADDR_W-1:BANK_ADDR_LSB]);
    end else begin : g_bank_one
      assign w_bank = '0;
    end
  endgenerate

  logic [SPRAM_DATA_W-1:0] w_bank_dout [NUM_BANKS];

  // Every bank sees the address (and reads every cycle); only the decoded
  // bank gets WREN.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic w_bank_hit;
      assign w_bank_hit = (w_bank == TAG_BANK_W'(gi));

      spram_bank u_spram_bank (
        .clk       (clk),
        .i_address (w_sel_addr[SPRAM_WORD_W:1]),
        .i_lane    (w_sel_addr[0]),
        .i_wdata   (w_sel_wdata),
        .i_wren    (w_wr & w_bank_hit),
        .o_dataout (w_bank_dout[gi])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Read-tag pipeline
  //   stage 1: aligned with the bank's registered read data
  //   stage 2: captured word + lane/port, bank already resolved
  // Bank and lane come from the tag, never from the live request inputs.
  // -------------------------------------------------------------------------
  rd_tag_t                 r_tag_s1;
  rd_sel_t                 r_tag_s2;
  logic [SPRAM_DATA_W-1:0] r_word_s2;
  logic [SPRAM_DATA_W-1:0] w_s1_word;

  always_comb begin
    w_s1_word = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (r_tag_s1.bank == TAG_BANK_W'(i)) begin
        w_s1_word = w_bank_dout[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Clearing the valids drops any read that was in flight.
      r_tag_s1  <= '0;
      r_tag_s2  <= '0;
      r_word_s2 <= '0;
    end else begin
      r_tag_s1 <= '{valid: w_rd, port: w_sel_port, bank: w_bank,
                    lane: w_sel_addr[0]};
      r_tag_s2 <= '{valid: r_tag_s1.valid, port: r_tag_s1.port,
                    lane: r_tag_s1.lane};
      if (r_tag_s1.valid) begin
        r_word_s2 <= w_s1_word;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-port output registers
  // -------------------------------------------------------------------------
  logic [7:0] w_s2_byte;
  logic       w_s2_a;
  logic       w_s2_b;
  logic [7:0] r_a_rdata;
  logic [7:0] r_b_rdata;
  logic       r_a_rvalid;
  logic       r_b_rvalid;

  assign w_s2_byte = r_tag_s2.lane ? r_word_s2[15:8] : r_word_s2[7:0];
  assign w_s2_a    = r_tag_s2.valid & (r_tag_s2.port == PORT_A);
  assign w_s2_b    = r_tag_s2.valid & (r_tag_s2.port == PORT_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_rdata  <= 8'h00;
      r_b_rdata  <= 8'h00;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_s2_a;
      r_b_rvalid <= w_s2_b;
      // Data registers only load on their own port's read, so they hold
      // the last returned byte between reads.
      if (w_s2_a) begin
        r_a_rdata <= w_s2_byte;
      end
      if (w_s2_b) begin
        r_b_rdata <= w_s2_byte;
      end
    end
  end

  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;

endmodule

// File: tb/tb_vram_spram_arb.sv
module tb_vram_spram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;

  // Round-robin instance (main DUT)
  logic        u1_a_gnt, u1_a_rvalid, u1_b_gnt, u1_b_rvalid;
  logic [7:0]  u1_a_rdata, u1_b_rdata;
  // Fixed-priority instance, used for the arbitration check
  logic        u2_a_gnt, u2_a_rvalid, u2_b_gnt, u2_b_rvalid;
  logic [7:0]  u2_a_rdata, u2_b_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vram_spram_arb #(.NUM_BANKS(2), .ARB_MODE(0)) u_dut_rr (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(u1_a_gnt), .a_rdata(u1_a_rdata), .a_rvalid(u1_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(u1_b_gnt), .b_rdata(u1_b_rdata), .b_rvalid(u1_b_rvalid)
  );

  vram_spram_arb #(.NUM_BANKS(2), .ARB_MODE(1)) u_dut_fix (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(u2_a_gnt), .a_rdata(u2_a_rdata), .a_rvalid(u2_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(u2_b_gnt), .b_rdata(u2_b_rdata), .b_rvalid(u2_b_rvalid)
  );

  typedef struct {
    logic        a_req;
    logic        a_we;
    logic [15:0] a_addr;
    logic [7:0]  a_wdata;
    logic        b_req;
    logic        b_we;
    logic [15:0] b_addr;
    logic [7:0]  b_wdata;
    logic        e_a_gnt;
    logic        e_b_gnt;
    logic        e_a_rvalid;
    logic [7:0]  e_a_rdata;
    logic        e_b_rvalid;
    logic [7:0]  e_b_rdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic ar, input logic aw, input logic [15:0] aa, input logic [7:0] ad,
    input logic br, input logic bw, input logic [15:0] ba, input logic [7:0] bd,
    input logic eag, input logic ebg,
    input logic earv, input logic [7:0] eard,
    input logic ebrv, input logic [7:0] ebrd);
    vec_t v;
    v.a_req = ar;  v.a_we = aw;  v.a_addr = aa;  v.a_wdata = ad;
    v.b_req = br;  v.b_we = bw;  v.b_addr = ba;  v.b_wdata = bd;
    v.e_a_gnt = eag;  v.e_b_gnt = ebg;
    v.e_a_rvalid = earv;  v.e_a_rdata = eard;
    v.e_b_rvalid = ebrv;  v.e_b_rdata = ebrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(
    input logic ar, input logic aw, input logic [15:0] aa, input logic [7:0] ad,
    input logic br, input logic bw, input logic [15:0] ba, input logic [7:0] bd);
    a_req = ar;  a_we = aw;  a_addr = aa;  a_wdata = ad;
    b_req = br;  b_we = bw;  b_addr = ba;  b_wdata = bd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- Table: one row per clock cycle ----------------
    //           A: req we addr     wdata  B: req we addr     wdata   gntA gntB  rvA rdA    rvB rdB
    // A writes 5A@0001 and B writes C3@0000 together: A wins the first tie
    vq.push_back(mk(1,1,16'h0001,8'h5A, 1,1,16'h0000,8'hC3, 1,0, 0,8'h00, 0,8'h00)); // 0
    vq.push_back(mk(0,0,16'h0000,8'h00, 1,1,16'h0000,8'hC3, 0,1, 0,8'h00, 0,8'h00)); // 1
    vq.push_back(mk(1,0,16'h0001,8'h00, 0,0,16'h0000,8'h00, 1,0, 0,8'h00, 0,8'h00)); // 2 rd 0001
    vq.push_back(mk(1,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 1,0, 0,8'h00, 0,8'h00)); // 3 rd 0000
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'h00, 0,8'h00)); // 4
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 1,8'h5A, 0,8'h00)); // 5
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 1,8'hC3, 0,8'h00)); // 6
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'hC3, 0,8'h00)); // 7 hold
    // Bank aliasing: 0x0004 and 0x8004 share word/lane but differ in bank
    vq.push_back(mk(1,1,16'h0004,8'h11, 0,0,16'h0000,8'h00, 1,0, 0,8'hC3, 0,8'h00)); // 8
    vq.push_back(mk(1,1,16'h8004,8'h22, 0,0,16'h0000,8'h00, 1,0, 0,8'hC3, 0,8'h00)); // 9
    vq.push_back(mk(0,0,16'h0000,8'h00, 1,0,16'h0004,8'h00, 0,1, 0,8'hC3, 0,8'h00)); // 10
    vq.push_back(mk(0,0,16'h0000,8'h00, 1,0,16'h8004,8'h00, 0,1, 0,8'hC3, 0,8'h00)); // 11
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'hC3, 0,8'h00)); // 12
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'hC3, 1,8'h11)); // 13
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'hC3, 1,8'h22)); // 14
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'hC3, 0,8'h22)); // 15
    // Fill 0x10..0x13, then four back-to-back reads
    vq.push_back(mk(1,1,16'h0010,8'hA0, 0,0,16'h0000,8'h00, 1,0, 0,8'hC3, 0,8'h22)); // 16
    vq.push_back(mk(1,1,16'h0011,8'hA1, 0,0,16'h0000,8'h00, 1,0, 0,8'hC3, 0,8'h22)); // 17
    vq.push_back(mk(1,1,16'h0012,8'hA2, 0,0,16'h0000,8'h00, 1,0, 0,8'hC3, 0,8'h22)); // 18
    vq.push_back(mk(1,1,16'h0013,8'hA3, 0,0,16'h0000,8'h00, 1,0, 0,8'hC3, 0,8'h22)); // 19
    vq.push_back(mk(1,0,16'h0010,8'h00, 0,0,16'h0000,8'h00, 1,0, 0,8'hC3, 0,8'h22)); // 20
    vq.push_back(mk(1,0,16'h0011,8'h00, 0,0,16'h0000,8'h00, 1,0, 0,8'hC3, 0,8'h22)); // 21
    vq.push_back(mk(1,0,16'h0012,8'h00, 0,0,16'h0000,8'h00, 1,0, 0,8'hC3, 0,8'h22)); // 22
    vq.push_back(mk(1,0,16'h0013,8'h00, 0,0,16'h0000,8'h00, 1,0, 1,8'hA0, 0,8'h22)); // 23
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 1,8'hA1, 0,8'h22)); // 24
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 1,8'hA2, 0,8'h22)); // 25
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 1,8'hA3, 0,8'h22)); // 26
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'hA3, 0,8'h22)); // 27
    // Neighbour 0x21 = 55, then AA@0x20, read-after-write next cycle
    vq.push_back(mk(0,0,16'h0000,8'h00, 1,1,16'h0021,8'h55, 0,1, 0,8'hA3, 0,8'h22)); // 28
    vq.push_back(mk(1,1,16'h0020,8'hAA, 0,0,16'h0000,8'h00, 1,0, 0,8'hA3, 0,8'h22)); // 29
    vq.push_back(mk(1,0,16'h0020,8'h00, 0,0,16'h0000,8'h00, 1,0, 0,8'hA3, 0,8'h22)); // 30
    vq.push_back(mk(1,0,16'h0021,8'h00, 0,0,16'h0000,8'h00, 1,0, 0,8'hA3, 0,8'h22)); // 31
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'hA3, 0,8'h22)); // 32
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 1,8'hAA, 0,8'h22)); // 33
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 1,8'h55, 0,8'h22)); // 34
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'h55, 0,8'h22)); // 35
    // Contended reads: A won last (row 31), so B first, then A; returns in grant order
    vq.push_back(mk(1,0,16'h0001,8'h00, 1,0,16'h0000,8'h00, 0,1, 0,8'h55, 0,8'h22)); // 36
    vq.push_back(mk(1,0,16'h0001,8'h00, 0,0,16'h0000,8'h00, 1,0, 0,8'h55, 0,8'h22)); // 37
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'h55, 0,8'h22)); // 38
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'h55, 1,8'hC3)); // 39
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 1,8'h5A, 0,8'hC3)); // 40
    vq.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0, 0,8'h5A, 0,8'hC3)); // 41

    // ---------------- Reset: requests high must not be granted ----------------
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0001, 8'hEE, 1'b1, 1'b1, 16'h0000, 8'hEE);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset a_gnt",    u1_a_gnt,    8'h00);
    chk("reset b_gnt",    u1_b_gnt,    8'h00);
    chk("reset a_rvalid", u1_a_rvalid, 8'h00);
    chk("reset b_rvalid", u1_b_rvalid, 8'h00);
    chk("reset a_rdata",  u1_a_rdata,  8'h00);
    chk("reset b_rdata",  u1_b_rdata,  8'h00);
    chk("reset fix b_gnt", u2_b_gnt,   8'h00);
    $display("reset: a_gnt=%0b b_gnt=%0b a_rdata=%02h b_rdata=%02h",
             u1_a_gnt, u1_b_gnt, u1_a_rdata, u1_b_rdata);
    next_cycle();
    rst = 1'b0;

    // ---------------- Arbitration: both request for 6 cycles ----------------
    for (int i = 0; i < 6; i++) begin
      logic exp_a;
      exp_a = (i % 2 == 0);
      drive(1'b1, 1'b1, 16'h0100, 8'h77, 1'b1, 1'b1, 16'h0102, 8'h66);
      @(negedge clk);
      chk($sformatf("arb rr a_gnt c%0d", i),  u1_a_gnt, {7'b0, exp_a});
      chk($sformatf("arb rr b_gnt c%0d", i),  u1_b_gnt, {7'b0, ~exp_a});
      chk($sformatf("arb fix a_gnt c%0d", i), u2_a_gnt, 8'h00);
      chk($sformatf("arb fix b_gnt c%0d", i), u2_b_gnt, 8'h01);
      $display("arb %0d: rr a_gnt=%0b b_gnt=%0b fix a_gnt=%0b b_gnt=%0b",
               i, u1_a_gnt, u1_b_gnt, u2_a_gnt, u2_b_gnt);
      next_cycle();
    end

    // ---------------- Table-driven vectors ----------------
    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].a_req, vq[k].a_we, vq[k].a_addr, vq[k].a_wdata,
            vq[k].b_req, vq[k].b_we, vq[k].b_addr, vq[k].b_wdata);
      @(negedge clk);
      chk($sformatf("vec%0d a_gnt", k),    u1_a_gnt,    {7'b0, vq[k].e_a_gnt});
      chk($sformatf("vec%0d b_gnt", k),    u1_b_gnt,    {7'b0, vq[k].e_b_gnt});
      chk($sformatf("vec%0d a_rvalid", k), u1_a_rvalid, {7'b0, vq[k].e_a_rvalid});
      chk($sformatf("vec%0d a_rdata", k),  u1_a_rdata,  vq[k].e_a_rdata);
      chk($sformatf("vec%0d b_rvalid", k), u1_b_rvalid, {7'b0, vq[k].e_b_rvalid});
      chk($sformatf("vec%0d b_rdata", k),  u1_b_rdata,  vq[k].e_b_rdata);
      $display("vec %0d: a_gnt=%0b b_gnt=%0b a_rv=%0b a_rd=%02h b_rv=%0b b_rd=%02h",
               k, u1_a_gnt, u1_b_gnt, u1_a_rvalid, u1_a_rdata, u1_b_rvalid, u1_b_rdata);
      next_cycle();
    end

    // ---------------- Reset with a read in flight ----------------
    drive(1'b1, 1'b0, 16'h0001, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    chk("inflight read a_gnt", u1_a_gnt, 8'h01);
    next_cycle();

    // A write attempt during reset must not reach memory.
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0001, 8'hFF, 1'b1, 1'b1, 16'h0000, 8'hFF);
    @(negedge clk);
    chk("midrst a_gnt", u1_a_gnt, 8'h00);
    chk("midrst b_gnt", u1_b_gnt, 8'h00);
    $display("midrst: a_gnt=%0b b_gnt=%0b", u1_a_gnt, u1_b_gnt);
    next_cycle();
    rst = 1'b0;
    idle();

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("postrst a_rvalid c%0d", c), u1_a_rvalid, 8'h00);
      chk($sformatf("postrst b_rvalid c%0d", c), u1_b_rvalid, 8'h00);
      chk($sformatf("postrst a_rdata c%0d", c),  u1_a_rdata,  8'h00);
      chk($sformatf("postrst b_rdata c%0d", c),  u1_b_rdata,  8'h00);
      $display("postrst %0d: a_rv=%0b a_rd=%02h b_rv=%0b b_rd=%02h",
               c, u1_a_rvalid, u1_a_rdata, u1_b_rvalid, u1_b_rdata);
      next_cycle();
    end

    // First tie after reset goes to A; contents survive reset.
    drive(1'b1, 1'b0, 16'h0001, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    chk("postrst tie a_gnt", u1_a_gnt, 8'h01);
    chk("postrst tie b_gnt", u1_b_gnt, 8'h00);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    chk("postrst b_gnt", u1_b_gnt, 8'h01);
    next_cycle();
    idle();
    @(negedge clk);
    chk("postrst early a_rvalid", u1_a_rvalid, 8'h00);
    next_cycle();
    @(negedge clk);
    chk("postrst a_rvalid", u1_a_rvalid, 8'h01);
    chk("postrst a_rdata",  u1_a_rdata,  8'h5A);
    $display("postrst read A: rv=%0b rd=%02h", u1_a_rvalid, u1_a_rdata);
    next_cycle();
    @(negedge clk);
    chk("postrst b_rvalid",    u1_b_rvalid, 8'h01);
    chk("postrst b_rdata",     u1_b_rdata,  8'hC3);
    chk("postrst a_rvalid end", u1_a_rvalid, 8'h00);
    $display("postrst read B: rv=%0b rd=%02h", u1_b_rvalid, u1_b_rdata);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
